seven_seg_digit_driver: RTL and testbench
=========================================

# seven_seg_digit_driver

Downstream consumer of the four-digit anode scanner. Takes the scanner's active-low one-hot anode select and a double-buffered 16-bit hex value, and drives the board's anode, cathode and decimal-point pins. Updates to the value are applied only at frame start, so the display never shows a mix of old and new digits. A programmable blanking interval on every anode change suppresses ghosting.

## Interface
- BLANK_CYCLES, 4: clk cycles of all-off output after each anode change; legal range 0..255.
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- anode_in  input  4  scanner anode select, active-low one-hot. 1110=R (digit 0), 1101=RC (1), 1011=LC (2), 0111=L (3).
- value_in  input  16  four hex nibbles. [3:0]=digit 0 … [15:12]=digit 3.
- dp_in  input  4  decimal-point request per digit, active-high.
- value_load  input  1  one-cycle strobe; captures value_in/dp_in into the shadow buffer.
- anode_out  output  4  anode pins, active-low.
- seg_out  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal-point cathode, active-low.
- load_pending  output  1  shadow holds a value not yet committed.

## Operation
- Reset values:
  - anode_out=1111, seg_out=7'h7F, dp_out=1, load_pending=0.
  - Shadow and active value/dp = 0; anode_q=1111; blank_cnt=0.
- anode_q <= anode_in every cycle.
- Anode change (anode_in != anode_q): blank_cnt <= BLANK_CYCLES. Otherwise blank_cnt decrements to 0 and saturates there.
- Load:
  - value_load=1 writes shadow and sets load_pending.
  - A second load before commit overwrites the shadow; last one wins.
- Commit: occurs on the cycle anode_in becomes 1110 while anode_q != 1110 (frame start).
  - If load_pending: active <= shadow, load_pending <= 0.
  - If value_load is high in the same cycle, value_in/dp_in go straight to active and load_pending ends 0.
- Output register, computed from anode_q, blank_cnt and active:
  - blank_cnt != 0, or anode_q not a valid one-hot-low code (e.g. 1111, 1100): all off (1111 / 7F / 1).
  - Otherwise: anode_out=anode_q, seg_out=hex decode of the selected nibble, dp_out=~dp bit of that digit.
- Hex decode: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset asserted mid-blank or mid-load returns to reset values. Any pending value is discarded.

## Timing
- An anode_in change sampled at edge t is in anode_q after edge t; the old digit remains on the outputs after edge t+1.
- Outputs are blank for BLANK_CYCLES cycles, from edge t+2 through edge t+1+BLANK_CYCLES.
- The new digit appears after edge t+2+BLANK_CYCLES.
- BLANK_CYCLES=0: 2-cycle latency, no blank.
- load_pending rises the cycle after value_load.
- A committed value is visible on digit 0 with the latency above.
- If the scanner dwell is shorter than BLANK_CYCLES+2, display stays blank. This is legal, not an error.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits 3, 2, 1 force seg_out=7F (anode still driven) when their nibble and all higher nibbles of active are 0.
  - Digit 0 is never blanked.
  - dp_out is unaffected.
- Undefined: all four digits are always decoded.

## Structure
- Package seven_seg_pkg holds:
  - SEG_OFF=7'h7F, ANODE_OFF=4'hF.
  - The four anode codes as named constants.
  - The 16-entry hex segment pattern constants.
- Sub-module hex_to_seven_seg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.

## Test plan
- Reset, hold anode_in=1110, no load → after 2+4 cycles: anode_out=1110, seg_out=40, dp_out=1.
- Load 16'h12AF, dp_in=0001, while scanning with 16-cycle dwell → load_pending=1 until next 1110 entry. Then digits R..L show 0E, 08, 24, 79, and dp_out=0 only on R.
- Two loads (1111, then 2222) within one frame → only 2222 is ever displayed; no frame shows a mix.
- value_load coincident with the frame-start cycle → value_in is committed immediately and load_pending stays 0.
- anode_in=1100 or 1111 → outputs all off. BLANK_CYCLES=0 build → a valid digit appears exactly 2 cycles after an anode change.
- With LEADING_ZERO_BLANK_EN and value 16'h0005 → L, LC, RC show 7F; R shows 12. Value 16'h0000 → R shows 40.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants and helpers for the seven-segment digit driver:
//   - all-off patterns for the anode and cathode pins
//   - the four active-low anode select codes
//   - the 16-entry active-low hex segment table, bit order {g,f,e,d,c,b,a}
//   - decode_anode(): maps an anode code to {valid, digit index}
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  localparam logic [3:0] ANODE_R  = 4'b1110;  // digit 0
  localparam logic [3:0] ANODE_RC = 4'b1101;  // digit 1
  localparam logic [3:0] ANODE_LC = 4'b1011;  // digit 2
  localparam logic [3:0] ANODE_L  = 4'b0111;  // digit 3

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    DIGIT_R  = 2'd0,
    DIGIT_RC = 2'd1,
    DIGIT_LC = 2'd2,
    DIGIT_L  = 2'd3
  } digit_e;

  typedef struct packed {
    logic   valid;
    digit_e digit;
  } anode_dec_t;

  // Anything other than exactly one low bit is not a displayable digit.
  function automatic anode_dec_t decode_anode(input logic [3:0] anode);
    anode_dec_t dec;
    dec.valid = 1'b1;
    dec.digit = DIGIT_R;
    case (anode)
      ANODE_R:  dec.digit = DIGIT_R;
      ANODE_RC: dec.digit = DIGIT_RC;
      ANODE_LC: dec.digit = DIGIT_LC;
      ANODE_L:  dec.digit = DIGIT_L;
      default:  dec.valid = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// hex_to_seven_seg
// Combinational 4-bit hex to active-low seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   seg     out 7  cathodes {g,f,e,d,c,b,a}, active-low
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seven_seg_digit_driver.sv
// seven_seg_digit_driver
// Drives anode, cathode and decimal-point pins from a scanner's active-low
// one-hot anode select and a double-buffered 16-bit hex value. New values are
// committed only at frame start (entry into digit 0), and every anode change
// is followed by BLANK_CYCLES cycles of all-off output to suppress ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zeros on
// digits 3..1; digit 0 and the decimal point are never suppressed).
// Ports:
//   clk           in   1   system clock
//   reset         in   1   synchronous active-high reset
//   anode_in      in   4   scanner anode select, active-low one-hot
//   value_in      in   16  four hex nibbles, [3:0] = digit 0
//   dp_in         in   4   decimal-point request per digit, active-high
//   value_load    in   1   strobe: capture value_in/dp_in into the shadow
//   anode_out     out  4   anode pins, active-low
//   seg_out       out  7   cathodes {g,f,e,d,c,b,a}, active-low
//   dp_out        out  1   decimal-point cathode, active-low
//   load_pending  out  1   shadow holds a value not yet committed
module seven_seg_digit_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_load,
  output logic [3:0]  anode_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        load_pending
);

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

  logic [3:0]  anode_q;       // anode_in sampled last edge
  logic [3:0]  anode_d;       // one more stage, aligned with the selected digit
  logic [7:0]  blank_cnt;
  logic [15:0] shadow_value;
  logic [3:0]  shadow_dp;
  logic [15:0] active_value;
  logic [3:0]  active_dp;
  logic [3:0]  nib_q;         // nibble of active for anode_d's digit
  logic        dp_sel_q;
  logic        lzb_q;         // leading-zero suppress for anode_d's digit

  logic        frame_start;
  anode_dec_t  dec_q;
  anode_dec_t  dec_d;
  logic [3:0]  sel_nib;
  logic        sel_dp;
  logic        sel_lzb;
  logic [6:0]  seg_decoded;

  assign frame_start = (anode_in == ANODE_R) && (anode_q != ANODE_R);

  // Pick the digit addressed by anode_q. It is registered together with
  // anode_d, so the digit on screen and its data always come from the same
  // snapshot: a commit at frame start cannot leak into the last cycle of the
  // previous digit 3.
  always_comb begin
    dec_q   = decode_anode(anode_q);
    sel_nib = active_value[3:0];
    sel_dp  = active_dp[0];
    sel_lzb = 1'b0;
    case (dec_q.digit)
      DIGIT_R: begin
        sel_nib = active_value[3:0];
        sel_dp  = active_dp[0];
      end
      DIGIT_RC: begin
        sel_nib = active_value[7:4];
        sel_dp  = active_dp[1];
`ifdef LEADING_ZERO_BLANK_EN
        sel_lzb = (active_value[15:4] == 12'h000);
`endif
      end
      DIGIT_LC: begin
        sel_nib = active_value[11:8];
        sel_dp  = active_dp[2];
`ifdef LEADING_ZERO_BLANK_EN
        sel_lzb = (active_value[15:8] == 8'h00);
`endif
      end
      default: begin
        sel_nib = active_value[15:12];
        sel_dp  = active_dp[3];
`ifdef LEADING_ZERO_BLANK_EN
        sel_lzb = (active_value[15:12] == 4'h0);
`endif
      end
    endcase
  end

  always_comb begin
    dec_d = decode_anode(anode_d);
  end

  hex_to_seven_seg u_hex (
    .nibble (nib_q),
    .seg    (seg_decoded)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_q      <= ANODE_OFF;
      anode_d      <= ANODE_OFF;
      blank_cnt    <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
      load_pending <= 1'b0;
      nib_q        <= '0;
      dp_sel_q     <= 1'b0;
      lzb_q        <= 1'b0;
      anode_out    <= ANODE_OFF;
      seg_out      <= SEG_OFF;
      dp_out       <= 1'b1;
    end else begin
      anode_q  <= anode_in;
      anode_d  <= anode_q;
      nib_q    <= sel_nib;
      dp_sel_q <= sel_dp;
      lzb_q    <= sel_lzb;

      // The change is detected one stage late so the blank window lines up
      // with the delayed anode/digit pair driving the pins.
      if (anode_q != anode_d) begin
        blank_cnt <= BLANK_LOAD;
      end else if (blank_cnt != 8'd0) begin
        blank_cnt <= blank_cnt - 8'd1;
      end

      if (frame_start && value_load) begin
        // Load coincident with frame start bypasses the shadow.
        active_value <= value_in;
        active_dp    <= dp_in;
        load_pending <= 1'b0;
      end else if (frame_start && load_pending) begin
        active_value <= shadow_value;
        active_dp    <= shadow_dp;
        load_pending <= 1'b0;
      end else if (value_load) begin
        shadow_value <= value_in;
        shadow_dp    <= dp_in;
        load_pending <= 1'b1;
      end

      if ((blank_cnt != 8'd0) || !dec_d.valid) begin
        anode_out <= ANODE_OFF;
        seg_out   <= SEG_OFF;
        dp_out    <= 1'b1;
      end else begin
        anode_out <= anode_d;
        seg_out   <= lzb_q ? SEG_OFF : seg_decoded;
        dp_out    <= ~dp_sel_q;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// tb_seven_seg_digit_driver
// Drives two instances (BLANK_CYCLES = 4 and 0) from the same stimulus and
// compares both against a cycle-history model on every falling edge, plus
// hand-computed literal expectations at selected points.
module tb_seven_seg_digit_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode_in;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_load;

  logic [3:0]  anode_out4, anode_out0;
  logic [6:0]  seg_out4, seg_out0;
  logic        dp_out4, dp_out0;
  logic        pend4, pend0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_digit_driver #(.BLANK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .anode_in(anode_in), .value_in(value_in),
    .dp_in(dp_in), .value_load(value_load), .anode_out(anode_out4),
    .seg_out(seg_out4), .dp_out(dp_out4), .load_pending(pend4)
  );

  seven_seg_digit_driver #(.BLANK_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .anode_in(anode_in), .value_in(value_in),
    .dp_in(dp_in), .value_load(value_load), .anode_out(anode_out0),
    .seg_out(seg_out0), .dp_out(dp_out0), .load_pending(pend0)
  );

  // ---------------- model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] codes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct {
    logic [3:0]  anode;
    logic [15:0] value;
    logic [3:0]  dp;
    int          age;    // edges since the last anode change
  } hist_t;

  localparam int AGE_MAX = 1000;

  hist_t       h1, h2;
  logic [3:0]  m_prev;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_active_dp, m_shadow_dp;
  logic        m_pending;
  logic [3:0]  e_anode4, e_anode0;
  logic [6:0]  e_seg4, e_seg0;
  logic        e_dp4, e_dp0, e_pend;
  bit          model_ready = 0;

  function automatic void expect_for(input hist_t h, input int b,
      output logic [3:0] ea, output logic [6:0] es, output logic ed);
    int d;
    logic [15:0] upper;
    d = -1;
    for (int i = 0; i < 4; i++) if (h.anode == codes[i]) d = i;
    ea = 4'hF; es = 7'h7F; ed = 1'b1;
    if (d >= 0 && h.age >= b) begin
      upper = h.value >> (4 * d);
      ea = h.anode;
      es = seg_tab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && upper == 16'h0) es = 7'h7F;
`endif
      ed = ~h.dp[d];
    end
  endfunction

  task automatic model_step();
    hist_t n;
    logic  fs;
    if (reset) begin
      e_anode4 = 4'hF; e_seg4 = 7'h7F; e_dp4 = 1'b1;
      e_anode0 = 4'hF; e_seg0 = 7'h7F; e_dp0 = 1'b1;
      m_prev = 4'hF; m_active = 0; m_active_dp = 0;
      m_shadow = 0; m_shadow_dp = 0; m_pending = 0;
      n.anode = 4'hF; n.value = 0; n.dp = 0; n.age = AGE_MAX;
    end else begin
      expect_for(h2, 4, e_anode4, e_seg4, e_dp4);
      expect_for(h2, 0, e_anode0, e_seg0, e_dp0);
      fs = (anode_in == 4'b1110) && (m_prev != 4'b1110);
      if (fs && value_load) begin
        m_active = value_in; m_active_dp = dp_in; m_pending = 0;
      end else if (fs && m_pending) begin
        m_active = m_shadow; m_active_dp = m_shadow_dp; m_pending = 0;
      end else if (value_load) begin
        m_shadow = value_in; m_shadow_dp = dp_in; m_pending = 1;
      end
      n.anode = anode_in; n.value = m_active; n.dp = m_active_dp;
      n.age = (anode_in != m_prev) ? 0 : ((h1.age < AGE_MAX) ? h1.age + 1 : AGE_MAX);
      m_prev = anode_in;
    end
    e_pend = m_pending;
    h2 = h1;
    h1 = n;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    h1.anode = 4'hF; h1.value = 0; h1.dp = 0; h1.age = AGE_MAX;
    h2 = h1;
    forever begin
      @(posedge clk);
      model_step();
      model_ready = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check("model_anode_b4", {12'h0, anode_out4}, {12'h0, e_anode4});
        check("model_seg_b4", {9'h0, seg_out4}, {9'h0, e_seg4});
        check("model_dp_b4", {15'h0, dp_out4}, {15'h0, e_dp4});
        check("model_pend_b4", {15'h0, pend4}, {15'h0, e_pend});
        check("model_anode_b0", {12'h0, anode_out0}, {12'h0, e_anode0});
        check("model_seg_b0", {9'h0, seg_out0}, {9'h0, e_seg0});
        check("model_dp_b0", {15'h0, dp_out0}, {15'h0, e_dp0});
        check("model_pend_b0", {15'h0, pend0}, {15'h0, e_pend});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; value_load = 1'b1;
    tick(1);
    value_load = 1'b0;
  endtask

  task automatic lit4(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    check({name, "_anode"}, {12'h0, anode_out4}, {12'h0, a});
    check({name, "_seg"}, {9'h0, seg_out4}, {9'h0, s});
    check({name, "_dp"}, {15'h0, dp_out4}, {15'h0, d});
  endtask

  // One 16-cycle-dwell frame R, RC, LC, L. Optional loads mid-dwell on the
  // digits in load_mask; optional literal check of each digit at dwell 10.
  task automatic frame(input logic chk, input logic [27:0] segs, input logic [3:0] dpl,
                       input logic [3:0] load_mask, input logic [63:0] lvals,
                       input logic [3:0] ldp);
    for (int d = 0; d < 4; d++) begin
      anode_in = codes[d];
      if (load_mask[d]) begin
        tick(5);
        do_load(lvals[16*d +: 16], ldp);
        check("pending_after_load", {15'h0, pend4}, 16'h1);
        tick(4);
      end else begin
        tick(10);
      end
      if (chk) lit4("frame_digit", codes[d], segs[7*d +: 7], dpl[d]);
      tick(6);
    end
  endtask

  initial begin
    reset = 1'b1; anode_in = 4'b1110; value_in = 0; dp_in = 0; value_load = 0;
    tick(3);
    reset = 1'b0;
    tick(2);  // after edge r+1
    lit4("reset_hold", 4'hF, 7'h7F, 1'b1);
    check("reset_pending", {15'h0, pend4}, 16'h0);
    tick(1);  // after edge r+2
    check("b0_first_digit_anode", {12'h0, anode_out0}, 16'hE);
    check("b4_still_blank", {12'h0, anode_out4}, 16'hF);
    tick(3);  // after edge r+5
    check("b4_last_blank", {12'h0, anode_out4}, 16'hF);
    tick(1);  // after edge r+6
    lit4("first_digit", 4'b1110, 7'h40, 1'b1);

    // Load 12AF mid-frame; pending until the next frame start.
    frame(0, 0, 0, 4'b0010, {16'h0, 16'h0, 16'h12AF, 16'h0}, 4'b0001);
    check("pending_held_to_frame_end", {15'h0, pend4}, 16'h1);
    frame(1, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1110, 4'b0000, 64'h0, 4'h0);
    check("pending_cleared", {15'h0, pend4}, 16'h0);

    // Two loads in one frame: last wins.
    frame(0, 0, 0, 4'b0110, {16'h0, 16'h2222, 16'h1111, 16'h0}, 4'b0000);
    frame(1, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, 4'b0000, 64'h0, 4'h0);

    // Load coincident with frame start commits directly.
    anode_in = 4'b1110;
    do_load(16'h3456, 4'b1000);
    check("coincident_pending", {15'h0, pend4}, 16'h0);
    tick(9);
    lit4("coincident_r", 4'b1110, 7'h02, 1'b1);
    tick(6);
    anode_in = 4'b0111;
    tick(16);
    frame(1, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0111, 4'b0000, 64'h0, 4'h0);

    // Invalid anode codes.
    anode_in = 4'b1100; tick(10);
    lit4("invalid_1100", 4'hF, 7'h7F, 1'b1);
    anode_in = 4'b1111; tick(10);
    lit4("invalid_1111", 4'hF, 7'h7F, 1'b1);

    // BLANK_CYCLES=0 latency and old-digit hold.
    anode_in = 4'b1101; tick(1);
    check("b0_t0_anode", {12'h0, anode_out0}, 16'hF);
    tick(1);
    check("b0_t1_anode", {12'h0, anode_out0}, 16'hF);
    tick(1);
    check("b0_t2_anode", {12'h0, anode_out0}, 16'hD);
    check("b0_t2_seg", {9'h0, seg_out0}, 16'h12);
    tick(12);
    anode_in = 4'b1011; tick(2);
    check("b0_old_digit_seg", {9'h0, seg_out0}, 16'h12);
    lit4("b4_old_digit", 4'b1101, 7'h12, 1'b1);
    tick(1);
    check("b0_new_digit_seg", {9'h0, seg_out0}, 16'h19);
    check("b4_blank_start", {12'h0, anode_out4}, 16'hF);
    tick(3);
    check("b4_blank_end", {12'h0, anode_out4}, 16'hF);
    tick(1);
    lit4("b4_new_digit", 4'b1011, 7'h19, 1'b1);

    // Dwell shorter than BLANK_CYCLES+2: stays blank.
    for (int i = 0; i < 8; i++) begin
      anode_in = codes[i % 4];
      tick(3);
      check("short_dwell_blank", {12'h0, anode_out4}, 16'hF);
    end

    // Reset mid-blank with a pending load.
    anode_in = 4'b1101; tick(2);
    do_load(16'h7777, 4'b1111);
    reset = 1'b1; tick(3);
    reset = 1'b0;
    check("reset_drops_pending", {15'h0, pend4}, 16'h0);
    lit4("reset_mid_blank", 4'hF, 7'h7F, 1'b1);
    anode_in = 4'b0111; tick(16);
    frame(0, 0, 0, 4'b0000, 64'h0, 4'h0);

    // Leading zeros.
    frame(0, 0, 0, 4'b0001, {48'h0, 16'h0005}, 4'b0000);
`ifdef LEADING_ZERO_BLANK_EN
    frame(1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111, 4'b0001, {48'h0, 16'h0000}, 4'b0000);
    frame(1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 4'b0000, 64'h0, 4'h0);
`else
    frame(1, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111, 4'b0001, {48'h0, 16'h0000}, 4'b0000);
    frame(1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0000, 64'h0, 4'h0);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
